// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// pipe_stage_skid_pkg: shared defaults and helpers for the inter-stage pipeline register.
// Revision 1.0
package pipe_stage_skid_pkg;

  localparam int DEF_DATA_W = 279;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_N_SRC  = 2;

  // Number of occupied entries given the main and skid valid bits.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction

endpackage : pipe_stage_skid_pkg
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// pipe_stage_skid_sat_counter: counter that sticks at all-ones, cleared only by rst.
// Revision 1.0
module pipe_stage_skid_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : pipe_stage_skid_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// pipe_stage_skid: valid/ready pipeline register with stall/flush, optional 2-entry skid.
// Revision 1.0
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W           = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_DATA         = '0,
  parameter int                N_STALL          = DEF_N_SRC,
  parameter int                N_FLUSH          = DEF_N_SRC,
  parameter int                SKID             = 1,
  parameter int                BUBBLE_ZERO      = 1,
  parameter int                FLUSH_OVER_STALL = 1,
  parameter int                CNT_W            = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic [N_STALL-1:0] stall_vec,
  input  logic [N_FLUSH-1:0] flush_vec,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  localparam logic BZ  = (BUBBLE_ZERO != 0);
  localparam logic FOS = (FLUSH_OVER_STALL != 0);

  logic              stall;
  logic              flush_eff;
  logic              out_fire;
  logic              in_fire;
  logic              valid_r;
  logic              skid_valid;
  logic [DATA_W-1:0] data_r;

  assign stall     = |stall_vec;
  assign flush_eff = (|flush_vec) & (FOS | ~stall);
  assign out_fire  = valid_r & out_ready & ~stall;
  assign in_fire   = in_valid & in_ready & ~flush_eff;

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign occ       = occ_count(valid_r, skid_valid);

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data;

      // Ready depends only on state, so upstream sees no combinational path from downstream.
      assign in_ready = ~skid_valid & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r    <= 1'b0;
          data_r     <= RST_DATA;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush_eff) begin
          valid_r    <= 1'b0;
          skid_valid <= 1'b0;
          if (BZ) begin
            data_r    <= '0;
            skid_data <= '0;
          end
        end else if (~valid_r | out_fire) begin
          if (skid_valid) begin
            valid_r    <= 1'b1;
            data_r     <= skid_data;
            skid_valid <= 1'b0;
            if (BZ) skid_data <= '0;
          end else if (in_fire) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
          end else begin
            valid_r <= 1'b0;
            if (BZ && valid_r) data_r <= '0;
          end
        end else if (in_fire) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end else begin : g_reg
      assign skid_valid = 1'b0;
      assign in_ready   = ~rst & (~valid_r | (out_ready & ~stall));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          data_r  <= RST_DATA;
        end else if (flush_eff) begin
          valid_r <= 1'b0;
          if (BZ) data_r <= '0;
        end else if (in_fire) begin
          valid_r <= 1'b1;
          data_r  <= in_data;
        end else if (out_fire) begin
          valid_r <= 1'b0;
          if (BZ) data_r <= '0;
        end
      end
    end
  endgenerate

  pipe_stage_skid_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_r & ~out_fire),
    .count (stall_cycles)
  );

  pipe_stage_skid_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_eff),
    .count (flush_count)
  );

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// tb_pipe_stage_skid: scoreboard bench for a skid instance (A) and a plain-register,
// stall-over-flush, 4-bit-counter instance (B) driven by the same stimulus.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic [1:0]  stall_vec;
  logic [1:0]  flush_vec;

  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall_cycles, a_flush_count;

  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall_cycles, b_flush_count;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] sb[$];
  logic [15:0] sb_exp;

  pipe_stage_skid #(
    .DATA_W(16), .RST_DATA(16'hBEEF), .N_STALL(2), .N_FLUSH(2), .SKID(1),
    .BUBBLE_ZERO(1), .FLUSH_OVER_STALL(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .stall_vec(stall_vec), .flush_vec(flush_vec), .occ(a_occ),
    .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
  );

  pipe_stage_skid #(
    .DATA_W(16), .RST_DATA(16'hBEEF), .N_STALL(2), .N_FLUSH(2), .SKID(0),
    .BUBBLE_ZERO(1), .FLUSH_OVER_STALL(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .stall_vec(stall_vec), .flush_vec(flush_vec), .occ(b_occ),
    .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for A: inputs are stable at negedge, so fire conditions match the next posedge.
  always @(negedge clk) begin
    if (rst || (|flush_vec)) begin
      sb.delete();
    end else begin
      if (a_out_valid && out_ready && !(|stall_vec)) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_underflow: got %h expected no output", a_out_data);
        end else begin
          sb_exp = sb.pop_front();
          if (a_out_data !== sb_exp) $display("FAIL sb_order: got %h expected %h", a_out_data, sb_exp);
          else passes++;
        end
      end
      if (in_valid && a_in_ready) sb.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_vec = '0; flush_vec = '0;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_vec = '0; flush_vec = '0;
    step(); step();
    checks++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); else passes++;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); else passes++;
    checks++; if (a_out_data !== 16'hBEEF) $display("FAIL rst_out_data: got %h expected beef", a_out_data); else passes++;
    checks++; if (a_occ !== 2'd0) $display("FAIL rst_occ: got %0d expected 0", a_occ); else passes++;
    checks++; if (a_stall_cycles !== 16'd0 || a_flush_count !== 16'd0)
      $display("FAIL rst_counters: got %h/%h expected 0/0", a_stall_cycles, a_flush_count); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", a_in_ready); else passes++;
    checks++; if (b_in_ready !== 1'b1) $display("FAIL post_rst_b_in_ready: got %b expected 1", b_in_ready); else passes++;
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'(i);
      step();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'(i))
        $display("FAIL stream_a[%0d]: got v=%b d=%h expected v=1 d=%h", i, a_out_valid, a_out_data, 16'(i)); else passes++;
      checks++; if (a_occ !== 2'd1) $display("FAIL stream_occ[%0d]: got %0d expected 1", i, a_occ); else passes++;
      checks++; if (b_out_data !== 16'(i)) $display("FAIL stream_b[%0d]: got %h expected %h", i, b_out_data, 16'(i)); else passes++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", a_out_valid); else passes++;
    checks++; if (a_stall_cycles !== 16'd0) $display("FAIL stream_stall_cycles: got %0d expected 0", a_stall_cycles); else passes++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
    step();
    checks++; if (a_out_data !== 16'h000A || a_occ !== 2'd1 || a_in_ready !== 1'b1)
      $display("FAIL skid_c1: got d=%h occ=%0d rdy=%b expected d=000a occ=1 rdy=1", a_out_data, a_occ, a_in_ready); else passes++;
    in_data = 16'h000B;
    step();
    checks++; if (a_out_data !== 16'h000A || a_occ !== 2'd2 || a_in_ready !== 1'b0)
      $display("FAIL skid_c2: got d=%h occ=%0d rdy=%b expected d=000a occ=2 rdy=0", a_out_data, a_occ, a_in_ready); else passes++;
    in_data = 16'h000C;
    step();
    checks++; if (a_out_data !== 16'h000A || a_occ !== 2'd2 || a_in_ready !== 1'b0)
      $display("FAIL skid_c3: got d=%h occ=%0d rdy=%b expected d=000a occ=2 rdy=0", a_out_data, a_occ, a_in_ready); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (a_out_data !== 16'h000B || a_occ !== 2'd1 || a_in_ready !== 1'b1)
      $display("FAIL skid_c4: got d=%h occ=%0d rdy=%b expected d=000b occ=1 rdy=1", a_out_data, a_occ, a_in_ready); else passes++;
    step();
    checks++; if (a_out_data !== 16'h000C || a_out_valid !== 1'b1)
      $display("FAIL skid_c5: got v=%b d=%h expected v=1 d=000c", a_out_valid, a_out_data); else passes++;
    in_valid = 1'b0;
    step();
    checks++; if (a_occ !== 2'd0 || sb.size() != 0)
      $display("FAIL skid_drain: got occ=%0d queue=%0d expected 0/0", a_occ, sb.size()); else passes++;
    checks++; if (a_stall_cycles !== 16'd2) $display("FAIL skid_stall_cycles: got %0d expected 2", a_stall_cycles); else passes++;
  endtask

  task automatic test_stall();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
    step();
    in_valid = 1'b0; stall_vec = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0055)
        $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=0055", i, a_out_valid, a_out_data); else passes++;
      checks++; if (b_in_ready !== 1'b0) $display("FAIL stall_b_ready[%0d]: got %b expected 0", i, b_in_ready); else passes++;
    end
    checks++; if (a_stall_cycles !== 16'd5) $display("FAIL stall_cycles: got %0d expected 5", a_stall_cycles); else passes++;
    stall_vec = 2'b00;
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL stall_release: got %b expected 0", a_out_valid); else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    checks++; if (a_occ !== 2'd2) $display("FAIL flush_pre_occ: got %0d expected 2", a_occ); else passes++;
    in_data = 16'h0033; flush_vec = 2'b10;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 16'h0000)
      $display("FAIL flush_empty: got v=%b occ=%0d d=%h expected v=0 occ=0 d=0000", a_out_valid, a_occ, a_out_data); else passes++;
    checks++; if (a_flush_count !== 16'd1) $display("FAIL flush_count: got %0d expected 1", a_flush_count); else passes++;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", a_in_ready); else passes++;
    flush_vec = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++; if (a_out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL flush_discard: got v=%b queue=%0d expected 0/0", a_out_valid, sb.size()); else passes++;
    checks++; if (a_stall_cycles !== 16'd7) $display("FAIL flush_stall_cycles: got %0d expected 7", a_stall_cycles); else passes++;
  endtask

  task automatic test_stall_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077;
    step();
    in_valid = 1'b0; stall_vec = 2'b01; flush_vec = 2'b01;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0)
      $display("FAIL sf_a_flush: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ); else passes++;
    checks++; if (a_flush_count !== 16'd1) $display("FAIL sf_a_flush_count: got %0d expected 1", a_flush_count); else passes++;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h0077)
      $display("FAIL sf_b_hold: got v=%b d=%h expected v=1 d=0077", b_out_valid, b_out_data); else passes++;
    checks++; if (b_flush_count !== 4'd0) $display("FAIL sf_b_flush_count: got %0d expected 0", b_flush_count); else passes++;
    stall_vec = 2'b00; flush_vec = 2'b00;
    step();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h0077)
      $display("FAIL sf_b_after: got v=%b d=%h expected v=1 d=0077", b_out_valid, b_out_data); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (b_out_valid !== 1'b0) $display("FAIL sf_b_drain: got %b expected 0", b_out_valid); else passes++;
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0099;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    checks++; if (b_stall_cycles !== 4'd10) $display("FAIL sat_b_mid: got %0d expected 10", b_stall_cycles); else passes++;
    repeat (10) step();
    checks++; if (b_stall_cycles !== 4'd15) $display("FAIL sat_b_end: got %0d expected 15", b_stall_cycles); else passes++;
    checks++; if (a_stall_cycles !== 16'd20) $display("FAIL sat_a_end: got %0d expected 20", a_stall_cycles); else passes++;
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h00AB;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 16'hBEEF || a_occ !== 2'd0 || a_in_ready !== 1'b0)
      $display("FAIL midrst_a: got v=%b d=%h occ=%0d rdy=%b expected 0/beef/0/0", a_out_valid, a_out_data, a_occ, a_in_ready); else passes++;
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== 16'hBEEF || b_stall_cycles !== 4'd0)
      $display("FAIL midrst_b: got v=%b d=%h cnt=%0d expected 0/beef/0", b_out_valid, b_out_data, b_stall_cycles); else passes++;
    checks++; if (a_stall_cycles !== 16'd0 || a_flush_count !== 16'd0)
      $display("FAIL midrst_counters: got %0d/%0d expected 0/0", a_stall_cycles, a_flush_count); else passes++;
    in_valid = 1'b0; rst = 1'b0;
    step();
    checks++; if (sb.size() != 0 || a_out_valid !== 1'b0)
      $display("FAIL final_empty: got queue=%0d v=%b expected 0/0", sb.size(), a_out_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_stall();
    test_flush();
    test_stall_flush();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire
